// File: rtl/multicycle_alu.sv
// multicycle_alu: single-issue ALU with a bit-serial shifter; shifts take shamt+1 cycles, all else 1
module multicycle_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] step;
    logic [4:0]      shamt;
    logic            is_shift;

    assign shamt     = src_b[4:0];
    assign is_shift  = (alu_control == 4'd7) || (alu_control == 4'd8) || (alu_control == 4'd9);
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign zero      = (res_q == '0);

    // Single-cycle result; shift codes only land here with shamt 0, which leaves src_a unchanged
    always_comb begin
        alu_res = '0;
        case (alu_control)
            4'd0:    alu_res = src_a + src_b;
            4'd1:    alu_res = src_a - src_b;
            4'd2:    alu_res = src_a & src_b;
            4'd3:    alu_res = src_a | src_b;
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'd5:    alu_res = src_a ^ src_b;
            4'd6:    alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            4'd7,
            4'd8,
            4'd9:    alu_res = src_a;
            default: alu_res = '0;
        endcase
    end

    // One-bit shift of the working register in the direction set by the captured op
    always_comb begin
        step = (op_q == 4'd7) ? {res_q[XLEN-2:0], 1'b0} :
               (op_q == 4'd8) ? {1'b0, res_q[XLEN-1:1]} :
                                {res_q[XLEN-1], res_q[XLEN-1:1]};
    end

    // Next-state logic: capture on accept, iterate in SHIFT, hold in DONE until consumed
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d = alu_control;
                if (is_shift && shamt != 5'd0) begin
                    state_d = SHIFT;
                    res_d   = src_a;
                    cnt_d   = shamt;
                end else begin
                    state_d = DONE;
                    res_d   = alu_res;
                    cnt_d   = 5'd0;
                end
            end
            SHIFT: begin
                res_d   = step;
                cnt_d   = cnt_q - 5'd1;
                state_d = (cnt_q == 5'd1) ? DONE : SHIFT;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight operation immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 4'd0;
            res_q   <= '0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
